port_merge: RTL and testbench

Frame-aware N:1 round-robin arbiter between the `routex` output ports and the single `port2axis` egress. It accepts whole frames from up to `NPORTS` router output ports and serialises them onto one port. Once a port is granted, it keeps the grant until its EOF beat is accepted. Output is registered through a 2-entry buffer, so every backpressure signal is driven from flops.

---
 rtl/port_merge_pkg.sv | 20 ++
 rtl/port_merge_obuf.sv | 84 ++++++++
 rtl/port_merge.sv | 152 +++++++++++++++
 tb/tb_port_merge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_merge_pkg.sv
// port_merge_pkg
// Shared types and constants for the port_merge frame arbiter.
//   state_t : arbiter FSM states (IDLE searches for a requester, BUSY
//             forwards one frame from the granted port).
//   beat_t  : one beat at the default width of 8 x 64-bit words.
//   SRCW    : width of a source-port index at the default port count.
package port_merge_pkg;

  localparam int NPORTS_DEF = 4;
  localparam int WORDS_DEF  = 8;
  localparam int SRCW       = $clog2(NPORTS_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic [WORDS_DEF-1:0][63:0] beat_t;

endpackage

// File: rtl/port_merge_obuf.sv
// port_merge_obuf
// Two-entry FIFO that registers the merged beat stream so that every
// handshake signal seen by neighbours comes from flops.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   push_i                    write {pushData_i, pushEof_i, pushSrc_i}
//   pop_i                     head consumed downstream
//   data_o, eof_o, src_o      head entry
//   valid_o                   FIFO not empty
//   cnt_o                     occupancy 0..2 (registered)
module port_merge_obuf #(
  parameter int DW = 512,
  parameter int SW = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] pushData_i,
  input  logic          pushEof_i,
  input  logic [SW-1:0] pushSrc_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          eof_o,
  output logic [SW-1:0] src_o,
  output logic          valid_o,
  output logic [1:0]    cnt_o
);

  logic [DW-1:0] dataMem_q [2];
  logic          eofMem_q  [2];
  logic [SW-1:0] srcMem_q  [2];
  logic          rdPtr_q;
  logic          wrPtr_q;
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic          doPush;
  logic          doPop;

  // The upstream gating already prevents a push when full; the local guard
  // keeps the FIFO safe on its own.
  assign doPop  = pop_i && (cnt_q != 2'd0);
  assign doPush = push_i && (cnt_q != 2'd2);

  always_comb begin
    cnt_d = cnt_q;
    case ({doPush, doPop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the head (and hence Q) reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        dataMem_q[i] <= '0;
        eofMem_q[i]  <= 1'b0;
        srcMem_q[i]  <= '0;
      end
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      if (doPush) begin
        dataMem_q[wrPtr_q] <= pushData_i;
        eofMem_q[wrPtr_q]  <= pushEof_i;
        srcMem_q[wrPtr_q]  <= pushSrc_i;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = dataMem_q[rdPtr_q];
  assign eof_o   = eofMem_q[rdPtr_q];
  assign src_o   = srcMem_q[rdPtr_q];
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/port_merge.sv
// port_merge
// Frame-aware N:1 round-robin merge. A granted port keeps the grant until
// its EOF beat is accepted, so frames never interleave. The output passes
// through a 2-entry buffer; D_BP and Q_VALID depend only on flops.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   D, D_VALID, D_EOF, D_BP    per-port input beats and backpressure
//   Q, Q_VALID, Q_EOF, Q_SRC   merged beat, valid, last beat, source port
//   Q_BP                       downstream backpressure
//   FRAME_CNT                  per-port completed-frame counters, present
//                              only when PORT_MERGE_STATS_EN is defined
module port_merge
  import port_merge_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int WORDS  = 8
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic [NPORTS-1:0][WORDS-1:0][63:0] D,
  input  logic [NPORTS-1:0]                  D_VALID,
  input  logic [NPORTS-1:0]                  D_EOF,
  output logic [NPORTS-1:0]                  D_BP,
  output logic [WORDS-1:0][63:0]             Q,
  output logic                               Q_VALID,
  output logic                               Q_EOF,
  output logic [$clog2(NPORTS)-1:0]          Q_SRC,
`ifdef PORT_MERGE_STATS_EN
  output logic [NPORTS-1:0][31:0]            FRAME_CNT,
`endif
  input  logic                               Q_BP
);

  localparam int SW = $clog2(NPORTS);
  localparam int DW = WORDS * 64;

  state_t        state_q, state_d;
  logic [SW-1:0] grant_q, grant_d;
  logic [SW-1:0] last_q,  last_d;
  logic [1:0]    cnt;
  logic          pushReady;
  logic          push;
  logic          pushEof;
  logic [DW-1:0] pushData;
  logic          pop;
  logic          found;
  logic [SW-1:0] pick;
  logic [SW-1:0] idx;
  logic [DW-1:0] headData;

  // Only the granted port may push, and only while the buffer has room.
  assign pushReady = (state_q == BUSY) && (cnt != 2'd2);
  assign push      = pushReady && D_VALID[grant_q];
  assign pushEof   = D_EOF[grant_q];
  assign pushData  = D[grant_q];
  assign pop       = Q_VALID && !Q_BP;

  always_comb begin
    D_BP = '1;
    for (int i = 0; i < NPORTS; i++) begin
      if (pushReady && (grant_q == SW'(i))) begin
        D_BP[i] = 1'b0;
      end
    end
  end

  // Round-robin search: walk from the lowest priority (last itself) up to
  // last+1 so that the final hit is the highest-priority requester. NPORTS
  // is a power of two, so SW-bit addition wraps modulo NPORTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      idx = last_q + SW'(k);
      if (D_VALID[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (push && pushEof) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to NPORTS-1 so port 0 is searched first after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= SW'(NPORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  port_merge_obuf #(
    .DW (DW),
    .SW (SW)
  ) u_obuf (
    .clk_i      (CLK),
    .rst_ni     (RST_N),
    .push_i     (push),
    .pushData_i (pushData),
    .pushEof_i  (pushEof),
    .pushSrc_i  (grant_q),
    .pop_i      (pop),
    .data_o     (headData),
    .eof_o      (Q_EOF),
    .src_o      (Q_SRC),
    .valid_o    (Q_VALID),
    .cnt_o      (cnt)
  );

  assign Q = headData;

`ifdef PORT_MERGE_STATS_EN
  logic [NPORTS-1:0][31:0] frameCnt_q;

  // Counts frames as their EOF beat enters the buffer; wraps naturally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frameCnt_q <= '0;
    end else if (push && pushEof) begin
      frameCnt_q[grant_q] <= frameCnt_q[grant_q] + 32'd1;
    end
  end

  assign FRAME_CNT = frameCnt_q;
`endif

endmodule

// File: tb/tb_port_merge.sv
// tb_port_merge
// Directed bench for port_merge (4 ports, 8 words). Per-port frame sources
// honour D_BP, a monitor records every beat leaving Q, and the recorded
// stream is compared with hand-computed order, flags and cycle stamps.
// The FRAME_CNT checks are built only when PORT_MERGE_STATS_EN is defined.
module tb_port_merge;
  import port_merge_pkg::*;

  localparam int NP = 4;
  localparam int NW = 8;

  typedef struct {
    int    port;
    beat_t data;
    bit    eof;
  } srcEntry_t;

  logic                        CLK = 1'b0;
  logic                        RST_N;
  logic [NP-1:0][NW-1:0][63:0] D;
  logic [NP-1:0]               D_VALID;
  logic [NP-1:0]               D_EOF;
  logic [NP-1:0]               D_BP;
  logic [NW-1:0][63:0]         Q;
  logic                        Q_VALID;
  logic                        Q_EOF;
  logic [SRCW-1:0]             Q_SRC;
  logic                        Q_BP;
`ifdef PORT_MERGE_STATS_EN
  logic [NP-1:0][31:0]         FRAME_CNT;
`endif

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  srcEntry_t srcQ[$];
  bit        qbpQ[$];
  beat_t     outData[$];
  bit        outEof[$];
  int        outSrc[$];
  int        outCyc[$];

  port_merge #(
    .NPORTS (NP),
    .WORDS  (NW)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .D         (D),
    .D_VALID   (D_VALID),
    .D_EOF     (D_EOF),
    .D_BP      (D_BP),
    .Q         (Q),
    .Q_VALID   (Q_VALID),
    .Q_EOF     (Q_EOF),
    .Q_SRC     (Q_SRC),
`ifdef PORT_MERGE_STATS_EN
    .FRAME_CNT (FRAME_CNT),
`endif
    .Q_BP      (Q_BP)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic beat_t mkBeat(input int p, input int f, input int b);
    beat_t r;
    for (int k = 0; k < NW; k++) begin
      r[k] = {16'hBEA7, 8'(p), 8'(f), 8'(b), 8'(k), 16'h5A5A};
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the oldest pending beat of each port.
  task automatic driveInputs();
    bit seen;
    D       = '0;
    D_VALID = '0;
    D_EOF   = '0;
    for (int p = 0; p < NP; p++) begin
      seen = 1'b0;
      for (int k = 0; k < srcQ.size(); k++) begin
        if (!seen && srcQ[k].port == p) begin
          D[p]       = srcQ[k].data;
          D_VALID[p] = 1'b1;
          D_EOF[p]   = srcQ[k].eof;
          seen       = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int port, input int frame, input int nBeats);
    srcEntry_t e;
    for (int b = 0; b < nBeats; b++) begin
      e.port = port;
      e.data = mkBeat(port, frame, b);
      e.eof  = (b == nBeats - 1);
      srcQ.push_back(e);
    end
    driveInputs();
  endtask

  task automatic dropFirst(input int port);
    int at;
    at = -1;
    for (int k = 0; k < srcQ.size(); k++) begin
      if (at < 0 && srcQ[k].port == port) at = k;
    end
    if (at >= 0) srcQ.delete(at);
  endtask

  // One clock: sample handshakes at the falling edge, then update sources.
  task automatic step();
    logic [NP-1:0] xfer;
    @(negedge CLK);
    xfer = D_VALID & ~D_BP;
    if (Q_VALID && !Q_BP) begin
      outData.push_back(Q);
      outEof.push_back(Q_EOF);
      outSrc.push_back(int'(Q_SRC));
      outCyc.push_back(cycle);
    end
    @(posedge CLK);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (xfer[p]) dropFirst(p);
    end
    if (qbpQ.size() > 0) Q_BP = qbpQ.pop_front();
    else                 Q_BP = 1'b0;
    driveInputs();
  endtask

  task automatic runUntil(input string tag, input int nBeats, input int budget);
    int k;
    k = 0;
    while (outData.size() < nBeats && k < budget) begin
      step();
      k++;
    end
    repeat (3) step();
    checkOutput({tag, "_beatcount"}, outData.size(), nBeats);
  endtask

  task automatic checkBeat(input string tag, input int i, input int port, input int frame,
                           input int b, input bit eof, input int cyc);
    if (i < outData.size()) begin
      checkOutput($sformatf("%s_b%0d_data", tag, i), outData[i], mkBeat(port, frame, b));
      checkOutput($sformatf("%s_b%0d_eof", tag, i), outEof[i], eof);
      checkOutput($sformatf("%s_b%0d_src", tag, i), outSrc[i], port);
      if (cyc >= 0) checkOutput($sformatf("%s_b%0d_cycle", tag, i), outCyc[i], cyc);
    end else begin
      checkOutput($sformatf("%s_b%0d_missing", tag, i), 0, 1);
    end
  endtask

  task automatic clearMonitor();
    outData.delete();
    outEof.delete();
    outSrc.delete();
    outCyc.delete();
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    srcQ.delete();
    qbpQ.delete();
    Q_BP = 1'b0;
    driveInputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    clearMonitor();
  endtask

  initial begin
    int n;
    RST_N   = 1'b0;
    Q_BP    = 1'b0;
    D       = '0;
    D_VALID = '0;
    D_EOF   = '0;

    // Reset values while reset is held.
    #12;
    checkOutput("rst_qvalid", Q_VALID, 1'b0);
    checkOutput("rst_qeof", Q_EOF, 1'b0);
    checkOutput("rst_qsrc", Q_SRC, 0);
    checkOutput("rst_q", Q, 0);
    checkOutput("rst_dbp", D_BP, 4'hF);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // T1: 3-beat frame on port 0, first beat on Q two cycles after request.
    $display("[TB] T1 single frame port 0");
    n = cycle;
    applyStimulus(0, 0, 3);
    runUntil("t1", 3, 20);
    for (int b = 0; b < 3; b++) checkBeat("t1", b, 0, 0, b, (b == 2), n + 2 + b);

    // T2: all ports hold two 2-beat frames from reset.
    $display("[TB] T2 four-port round robin");
    doReset();
    n = cycle;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < NP; p++) applyStimulus(p, f, 2);
    end
    runUntil("t2", 16, 100);
    for (int j = 0; j < 8; j++) begin
      checkBeat("t2", 2 * j,     j % 4, j / 4, 0, 1'b0, n + 2 + 3 * j);
      checkBeat("t2", 2 * j + 1, j % 4, j / 4, 1, 1'b1, n + 3 + 3 * j);
    end

    // T3: port 2 frame under backpressure, port 1 requests mid-frame.
    $display("[TB] T3 backpressure and grant hold");
    clearMonitor();
    Q_BP = 1'b1;
    qbpQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    applyStimulus(2, 0, 4);
    step();
    applyStimulus(1, 0, 2);
    step();
    checkOutput("t3_dbp_cnt1", D_BP, 4'b1011);
    step();
    checkOutput("t3_dbp_full", D_BP, 4'b1111);
    checkOutput("t3_qvalid_full", Q_VALID, 1'b1);
    runUntil("t3", 6, 60);
    for (int b = 0; b < 4; b++) checkBeat("t3", b, 2, 0, b, (b == 3), -1);
    checkBeat("t3", 4, 1, 0, 0, 1'b0, -1);
    checkBeat("t3", 5, 1, 0, 1, 1'b1, -1);
    qbpQ.delete();
    Q_BP = 1'b0;

    // T4: single-beat frames alternate between ports 1 and 3.
    $display("[TB] T4 single-beat frames");
    doReset();
    n = cycle;
    for (int f = 0; f < 3; f++) begin
      applyStimulus(1, f, 1);
      applyStimulus(3, f, 1);
    end
    runUntil("t4", 6, 60);
    for (int j = 0; j < 6; j++) begin
      checkBeat("t4", j, (j % 2 == 0) ? 1 : 3, j / 2, 0, 1'b1, n + 2 + 2 * j);
    end

    // T5: reset in the middle of a 5-beat frame on port 2.
    $display("[TB] T5 reset mid-frame");
    clearMonitor();
    applyStimulus(1, 5, 1);
    applyStimulus(2, 0, 5);
    repeat (5) step();
    checkOutput("t5_pre_qvalid", Q_VALID, 1'b1);
    checkOutput("t5_pre_qsrc", Q_SRC, 2);
    checkOutput("t5_pre_dbp", D_BP, 4'b1011);
    #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t5_rst_qvalid", Q_VALID, 1'b0);
    checkOutput("t5_rst_dbp", D_BP, 4'hF);
    checkOutput("t5_rst_q", Q, 0);
    doReset();
    n = cycle;
    applyStimulus(3, 9, 2);
    applyStimulus(0, 9, 2);
    runUntil("t5", 4, 40);
    checkBeat("t5", 0, 0, 9, 0, 1'b0, n + 2);
    checkBeat("t5", 1, 0, 9, 1, 1'b1, n + 3);
    checkBeat("t5", 2, 3, 9, 0, 1'b0, n + 5);
    checkBeat("t5", 3, 3, 9, 1, 1'b1, n + 6);

`ifdef PORT_MERGE_STATS_EN
    // T6: frame counters.
    $display("[TB] T6 frame counters");
    doReset();
    for (int f = 0; f < 5; f++) applyStimulus(3, f, 1);
    for (int f = 0; f < 2; f++) applyStimulus(0, f, 2);
    runUntil("t6", 9, 100);
    checkOutput("t6_cnt0", FRAME_CNT[0], 32'd2);
    checkOutput("t6_cnt1", FRAME_CNT[1], 32'd0);
    checkOutput("t6_cnt2", FRAME_CNT[2], 32'd0);
    checkOutput("t6_cnt3", FRAME_CNT[3], 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
